uart_cmd_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 76 +++++++
 rtl/uart_cmd_rx_if.sv | 47 ++++
 rtl/uart_byte_rx.sv | 150 +++++++++++++++
 rtl/uart_cmd_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART command receiver and the
// status-dump transmitter that sits on the same pins and clock.
//
// Contents:
//   DELAY_FRAMES_DEFAULT    clock cycles per bit (27 MHz / 115200 baud)
//   TIMEOUT_CYCLES_DEFAULT  inter-byte abort limit (100 ms at 27 MHz)
//   CMD_FEED..CMD_STATUS    command codes delivered on cmd_code
//   ASCII_CR, ASCII_LF      line terminator / ignored line feed
//   rx_state_t              byte receiver states
//   parse_state_t           command line parser states
//   decode_letter()         command letter -> code (case-insensitive)
//   is_digit()              '0'..'9' test
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DELAY_FRAMES_DEFAULT   = 234;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 2700000;

    localparam logic [2:0] CMD_FEED   = 3'd0;
    localparam logic [2:0] CMD_PLAY   = 3'd1;
    localparam logic [2:0] CMD_BATH   = 3'd2;
    localparam logic [2:0] CMD_SLEEP  = 3'd3;
    localparam logic [2:0] CMD_WAKE   = 3'd4;
    localparam logic [2:0] CMD_TALK   = 3'd5;
    localparam logic [2:0] CMD_STATUS = 3'd6;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        P_WAIT_CMD,
        P_WAIT_ARG,
        P_WAIT_CR,
        P_DISCARD
    } parse_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } cmd_decode_t;

    // Setting bit 5 folds upper-case letters onto lower case; for the
    // letters matched here no non-letter byte can alias onto them.
    function automatic cmd_decode_t decode_letter(input logic [7:0] b);
        cmd_decode_t r;
        r.hit  = 1'b1;
        r.code = CMD_FEED;
        case (b | 8'h20)
            8'h66:   r.code = CMD_FEED;   // f
            8'h70:   r.code = CMD_PLAY;   // p
            8'h62:   r.code = CMD_BATH;   // b
            8'h73:   r.code = CMD_SLEEP;  // s
            8'h77:   r.code = CMD_WAKE;   // w
            8'h74:   r.code = CMD_TALK;   // t
            8'h71:   r.code = CMD_STATUS; // q
            default: r.hit  = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx_if -- serial input and command strobes of uart_cmd_rx.
//
// Signals:
//   uart_rx          serial line into the receiver (idle high, async)
//   cmd_valid        one-cycle strobe: command line accepted
//   cmd_code[2:0]    command code, valid with cmd_valid, held afterwards
//   cmd_arg[3:0]     argument 0..9, valid with cmd_valid, held afterwards
//   cmd_err          one-cycle strobe: malformed line rejected at CR
//   frame_err        one-cycle strobe: stop bit sampled low
//   busy             byte in flight or command line partially parsed
//   rx_state_dbg     byte receiver FSM state (observation only)
//   parse_state_dbg  parser FSM state (observation only)
//
// Handshake: cmd_valid, cmd_err and frame_err are push-only strobes with no
// ready/back-pressure; the consumer must act in the single cycle they are
// high. cmd_code/cmd_arg stay stable from one accept until the next.
//
// Modports: master = the receiver (drives strobes), slave = the consumer
// side that owns the serial line.
// ---------------------------------------------------------------------------
interface uart_cmd_rx_if;
    import uart_pkg::*;

    logic         uart_rx;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic [3:0]   cmd_arg;
    logic         cmd_err;
    logic         frame_err;
    logic         busy;
    rx_state_t    rx_state_dbg;
    parse_state_t parse_state_dbg;

    modport master (
        input  uart_rx,
        output cmd_valid, cmd_code, cmd_arg, cmd_err, frame_err, busy,
        output rx_state_dbg, parse_state_dbg
    );

    modport slave (
        output uart_rx,
        input  cmd_valid, cmd_code, cmd_arg, cmd_err, frame_err, busy,
        input  rx_state_dbg, parse_state_dbg
    );

endinterface

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx -- 8N1 byte receiver: 2-flop synchroniser plus RX FSM.
//
// Parameters:
//   DELAY_FRAMES  clock cycles per bit
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   rx_i           raw serial line (asynchronous, idle high)
//   byte_o         last received byte, stable while byte_strobe_o is high
//   byte_strobe_o  one cycle, the cycle after a good stop bit is sampled
//   frame_err_o    one cycle, the cycle after a low stop bit is sampled
//   idle_o         receiver in IDLE
//   state_o        receiver FSM state (observation)
// ---------------------------------------------------------------------------
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_strobe_o,
    output logic       frame_err_o,
    output logic       idle_o,
    output rx_state_t  state_o
);

    localparam int unsigned    CW        = $clog2(DELAY_FRAMES) + 1;
    localparam logic [CW-1:0]  HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(DELAY_FRAMES - 1);

    logic          sync1_q, sync2_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_strobe_q, byte_strobe_d;
    logic          frame_err_q, frame_err_d;

    logic rx_s;
    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sync1_q       <= rx_i;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_strobe_q <= byte_strobe_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // The counter restarts at every sample point, so it only ever counts up
    // to FULL_LAST and never wraps inside a bit period.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_strobe_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                end
            end

            // Re-check the start bit at its middle; a high line here was a
            // glitch and is dropped silently.
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = RX_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};   // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_strobe_d = 1'b1;
                        state_d       = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // A low stop bit usually means a break or a wrong baud rate;
            // nothing is decoded until the line has returned high.
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end

            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o        = shift_q;
    assign byte_strobe_o = byte_strobe_q;
    assign frame_err_o   = frame_err_q;
    assign idle_o        = (state_q == RX_IDLE);
    assign state_o       = state_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx -- host-to-pet command path. Receives 8N1 bytes and parses
// short ASCII lines: letter, optional decimal digit, CR. LF is ignored.
// Letters (any case): F feed, P play, B bath, S sleep, W wake, T talk,
// Q status. Without a digit the argument defaults to 1.
//
// Parameters:
//   DELAY_FRAMES    clock cycles per bit
//   TIMEOUT_CYCLES  inter-byte abort limit (only with CMD_TIMEOUT_EN)
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_cmd_rx_if.master: uart_rx in; cmd_valid, cmd_code, cmd_arg,
//         cmd_err, frame_err, busy and FSM state observation out
//
// Build option:
//   CMD_TIMEOUT_EN  when defined, a partial line left idle for
//                   TIMEOUT_CYCLES cycles is dropped silently; otherwise a
//                   partial line waits for its CR indefinitely.
// ---------------------------------------------------------------------------
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES   = DELAY_FRAMES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_rx_if.master bus
);

    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        rx_ferr;
    logic        rx_idle;
    rx_state_t   rx_state;

    uart_byte_rx #(
        .DELAY_FRAMES (DELAY_FRAMES)
    ) u_byte_rx (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (bus.uart_rx),
        .byte_o        (rx_byte),
        .byte_strobe_o (rx_strobe),
        .frame_err_o   (rx_ferr),
        .idle_o        (rx_idle),
        .state_o       (rx_state)
    );

    parse_state_t pstate_q, pstate_d;
    logic [2:0]   pend_code_q, pend_code_d;
    logic [3:0]   pend_arg_q, pend_arg_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic [2:0]   cmd_code_q, cmd_code_d;
    logic [3:0]   cmd_arg_q, cmd_arg_d;
    logic         cmd_err_q, cmd_err_d;
    logic         timeout_hit;
    cmd_decode_t  dec;

    assign dec = decode_letter(rx_byte);

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;

    // Counts idle line time inside a partial line; any received byte
    // restarts it, and it is held clear while no line is open.
    always_ff @(posedge clk) begin
        if (rst || rx_strobe || (pstate_q == P_WAIT_CMD)) begin
            to_cnt_q <= '0;
        end else if (rx_idle) begin
            if (to_cnt_q == TO_LAST) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    assign timeout_hit = rx_idle && (pstate_q != P_WAIT_CMD) && (to_cnt_q == TO_LAST);
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q    <= P_WAIT_CMD;
            pend_code_q <= CMD_FEED;
            pend_arg_q  <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 3'd0;
            cmd_arg_q   <= 4'd0;
            cmd_err_q   <= 1'b0;
        end else begin
            pstate_q    <= pstate_d;
            pend_code_q <= pend_code_d;
            pend_arg_q  <= pend_arg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // byte strobe and frame error come from the same stop-bit sample and
    // are therefore never high together.
    always_comb begin
        pstate_d    = pstate_q;
        pend_code_d = pend_code_q;
        pend_arg_d  = pend_arg_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_err_d   = 1'b0;

        if (rx_ferr) begin
            // A corrupted byte poisons a line already in progress.
            if (pstate_q != P_WAIT_CMD) begin
                pstate_d = P_DISCARD;
            end
        end else if (rx_strobe && (rx_byte != ASCII_LF)) begin
            case (pstate_q)
                P_WAIT_CMD: begin
                    if (dec.hit) begin
                        pend_code_d = dec.code;
                        pend_arg_d  = 4'd1;
                        pstate_d    = P_WAIT_ARG;
                    end else if (rx_byte != ASCII_CR) begin
                        pstate_d = P_DISCARD;
                    end
                end

                P_WAIT_ARG: begin
                    if (is_digit(rx_byte)) begin
                        // '0'..'9' are 0x30..0x39: the low nibble is the value.
                        pend_arg_d = rx_byte[3:0];
                        pstate_d   = P_WAIT_CR;
                    end else if (rx_byte == ASCII_CR) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = pend_code_q;
                        cmd_arg_d   = pend_arg_q;
                        pstate_d    = P_WAIT_CMD;
                    end else begin
                        pstate_d = P_DISCARD;
                    end
                end

                P_WAIT_CR: begin
                    if (rx_byte == ASCII_CR) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = pend_code_q;
                        cmd_arg_d   = pend_arg_q;
                        pstate_d    = P_WAIT_CMD;
                    end else begin
                        pstate_d = P_DISCARD;
                    end
                end

                P_DISCARD: begin
                    if (rx_byte == ASCII_CR) begin
                        cmd_err_d = 1'b1;
                        pstate_d  = P_WAIT_CMD;
                    end
                end

                default: pstate_d = P_WAIT_CMD;
            endcase
        end else if (timeout_hit) begin
            pstate_d = P_WAIT_CMD;
        end
    end

    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.cmd_code        = cmd_code_q;
    assign bus.cmd_arg         = cmd_arg_q;
    assign bus.cmd_err         = cmd_err_q;
    assign bus.frame_err       = rx_ferr;
    assign bus.busy            = !rx_idle || (pstate_q != P_WAIT_CMD);
    assign bus.rx_state_dbg    = rx_state;
    assign bus.parse_state_dbg = pstate_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx -- bench for uart_cmd_rx at DELAY_FRAMES=8.
// Fixed vector table, hand sequences for framing error, start glitch,
// reset mid-byte and (with CMD_TIMEOUT_EN) the line timeout, then random
// lines checked against a line-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;
  import uart_pkg::*;

  localparam int DF = 8;
  localparam int TO = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(
    .DELAY_FRAMES   (DF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];          // {code, arg} of expected accepts
  int exp_err  = 0;
  int exp_ferr = 0;
  int got_err  = 0;
  int got_ferr = 0;
  logic [6:0] mon_e;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid || bus.cmd_err || bus.frame_err) begin
        total++;
        if (int'(bus.cmd_valid) + int'(bus.cmd_err) + int'(bus.frame_err) > 1) begin
          bad++;
          $display("FAIL strobe_exclusive: valid=%0b err=%0b ferr=%0b, required at most one",
                   bus.cmd_valid, bus.cmd_err, bus.frame_err);
        end
      end
      if (bus.cmd_err)   got_err++;
      if (bus.frame_err) got_ferr++;
      if (bus.cmd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_valid_unexpected: code=%0d arg=%0d, required no command",
                   bus.cmd_code, bus.cmd_arg);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.cmd_code, bus.cmd_arg} !== mon_e) begin
            bad++;
            $display("FAIL cmd_value: code=%0d arg=%0d, required code=%0d arg=%0d",
                     bus.cmd_code, bus.cmd_arg, mon_e[6:4], mon_e[3:0]);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (DF) @(negedge clk);
    end
    bus.uart_rx = stop_bit;
    repeat (DF) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    repeat (4 * DF) @(negedge clk);
  endtask

  task automatic check_line_end(input string tag);
    check({tag, "_err_count"}, got_err, exp_err);
    check({tag, "_ferr_count"}, got_ferr, exp_ferr);
    check({tag, "_pending_cmds"}, exp_q.size(), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // ---------------- reference model (line level) ----------------
  logic [7:0] seg[$];     // non-LF bytes of the current line
  bit         seg_poison;

  function automatic int letter_code(input logic [7:0] b);
    string letters = "FPBSWTQ";
    for (int i = 0; i < 7; i++)
      if ((b & 8'hDF) == letters[i]) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int lc;
    logic [7:0] d;
    if (b == 8'h0A) return;
    if (b != 8'h0D) begin
      seg.push_back(b);
      return;
    end
    if (seg.size() > 0) begin
      lc = letter_code(seg[0]);
      if (!seg_poison && lc >= 0 && seg.size() == 1) begin
        exp_q.push_back({3'(lc), 4'd1});
      end else if (!seg_poison && lc >= 0 && seg.size() == 2 &&
                   seg[1] >= 8'h30 && seg[1] <= 8'h39) begin
        d = seg[1] - 8'h30;
        exp_q.push_back({3'(lc), d[3:0]});
      end else begin
        exp_err++;
      end
    end
    seg.delete();
    seg_poison = 1'b0;
  endtask

  task automatic model_ferr();
    exp_ferr++;
    if (seg.size() > 0) seg_poison = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string line;
    int    nvalid;
    int    code;
    int    arg;
    int    nerr;
  } vec_t;

  vec_t vecs[13];

  // ---------------- test sequence ----------------
  initial begin
    bit seen_hi, fell;
    int base_err, base_ferr;
    logic [7:0] b;
    string letters;

    vecs[0]  = '{"F3\015",           1, 0, 3, 0};
    vecs[1]  = '{"s\015\012",        1, 3, 1, 0};
    vecs[2]  = '{"X9\015",           0, 0, 0, 1};
    vecs[3]  = '{"Q\015",            1, 6, 1, 0};
    vecs[4]  = '{"P\015",            1, 1, 1, 0};
    vecs[5]  = '{"b7\015",           1, 2, 7, 0};
    vecs[6]  = '{"w\015",            1, 4, 1, 0};
    vecs[7]  = '{"T0\015",           1, 5, 0, 0};
    vecs[8]  = '{"\015",             0, 0, 0, 0};
    vecs[9]  = '{"F33\015",          0, 0, 0, 1};
    vecs[10] = '{"f\0125\015",       1, 0, 5, 0};
    vecs[11] = '{"9F\015",           0, 0, 0, 1};
    vecs[12] = '{"\012\012S\015",    1, 3, 1, 0};

    bus.uart_rx = 1'b1;
    seg_poison  = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", int'(bus.cmd_valid), 0);
    check("rst_cmd_err",   int'(bus.cmd_err), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_cmd_code",  int'(bus.cmd_code), 0);
    check("rst_cmd_arg",   int'(bus.cmd_arg), 0);
    check("rst_parse_state", int'(bus.parse_state_dbg), int'(P_WAIT_CMD));
    check("rst_rx_state",    int'(bus.rx_state_dbg), int'(RX_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);

    // table-driven lines
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].nvalid != 0) exp_q.push_back({3'(vecs[i].code), 4'(vecs[i].arg)});
      exp_err += vecs[i].nerr;
      send_str(vecs[i].line);
      drain();
      check_line_end($sformatf("vec%0d", i));
    end

    // stop bit low, then line held low for 20 bits
    exp_ferr++;
    b = 8'h46;
    bus.uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (DF) @(negedge clk);
    end
    bus.uart_rx = 1'b0;
    repeat (21 * DF) @(negedge clk);
    check("break_ferr_count", got_ferr, exp_ferr);
    check("break_busy_held", int'(bus.busy), 1);
    bus.uart_rx = 1'b1;
    drain();
    check_line_end("break_release");
    exp_q.push_back({CMD_PLAY, 4'd1});
    send_str("P\015");
    drain();
    check_line_end("break_then_P");

    // 2-cycle glitch on the idle line
    base_err  = got_err;
    base_ferr = got_ferr;
    bus.uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.uart_rx = 1'b1;
    seen_hi = 1'b0;
    fell    = 1'b0;
    for (int i = 0; i < DF / 2 + 3; i++) begin
      @(negedge clk);
      if (bus.busy) seen_hi = 1'b1;
      else if (seen_hi) begin
        fell = 1'b1;
        break;
      end
    end
    check("glitch_busy_rose", int'(seen_hi), 1);
    check("glitch_busy_fell", int'(fell), 1);
    drain();
    check("glitch_no_err",  got_err,  base_err);
    check("glitch_no_ferr", got_ferr, base_ferr);
    check_line_end("glitch");

    // reset in the middle of "B" while a line is open
    send_byte("F");
    b = "B";
    bus.uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.uart_rx = b[i];
      repeat (DF) @(negedge clk);
    end
    rst = 1'b1;
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_cmd_valid",   int'(bus.cmd_valid), 0);
    check("midrst_cmd_err",     int'(bus.cmd_err), 0);
    check("midrst_frame_err",   int'(bus.frame_err), 0);
    check("midrst_busy",        int'(bus.busy), 0);
    check("midrst_parse_state", int'(bus.parse_state_dbg), int'(P_WAIT_CMD));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back({CMD_BATH, 4'd1});
    send_str("B\015");
    drain();
    check_line_end("midrst_then_B");

`ifdef CMD_TIMEOUT_EN
    // partial line abandoned by the inter-byte timeout
    send_byte("T");
    repeat (250) @(negedge clk);
    check("timeout_parse_state", int'(bus.parse_state_dbg), int'(P_WAIT_CMD));
    send_byte(8'h0D);
    drain();
    check_line_end("timeout");
`endif

    // random lines against the line-level model
    letters = "FPBSWTQ";
    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) begin
        int kind;
        kind = $urandom_range(0, 99);
        if (kind < 40) begin
          b = letters[$urandom_range(0, 6)];
          if ($urandom_range(0, 1) == 1) b = b | 8'h20;
        end else if (kind < 70) begin
          b = 8'h30 + 8'($urandom_range(0, 9));
        end else if (kind < 85) begin
          b = 8'h0A;
        end else begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0D) b = 8'h21;
        end
        if ($urandom_range(0, 99) < 8) begin
          model_ferr();
          send_frame(8'($urandom_range(0, 255)), 1'b0);
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        model_byte(b);
        send_byte(b);
      end
      model_byte(8'h0D);
      send_byte(8'h0D);
      if ($urandom_range(0, 3) == 0) begin
        model_byte(8'h0A);
        send_byte(8'h0A);
      end
      drain();
      check_line_end($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
